// File: rtl/rv32_instr_decoder.sv
// RV32IM decode stage: one-hot opcode vector, register fields and immediate, registered
// behind a valid/ready output stage with a one-entry skid. M-extension gated by RV32_DECODE_M_EXT_EN.
module rv32_instr_decoder #(
    parameter int ONEHOT_W = 48,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] instructions,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic [4:0]          rd_addr,
    output logic                rd_we,
    output logic [31:0]         imm,
    output logic [PC_W-1:0]     out_pc,
    output logic                illegal
);

    typedef struct packed {
        logic [ONEHOT_W-1:0] oh;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                we;
        logic [31:0]         imm;
        logic [PC_W-1:0]     pc;
        logic                ill;
    } entry_t;

    logic [6:0]          w_opc;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;
    logic [31:0]         w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [ONEHOT_W-1:0] w_oh;
    logic [31:0]         w_imm_fmt;
    logic                w_writes;
    logic                w_illegal;
    logic                w_accept;
    entry_t              w_new;

    entry_t r_out, r_skid;
    logic   r_out_valid, r_skid_valid, r_in_ready;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        w_oh      = '0;
        w_imm_fmt = '0;
        w_writes  = 1'b0;
        case (w_opc)
            7'b0110111: begin w_oh[0] = 1'b1; w_imm_fmt = w_imm_u; w_writes = 1'b1; end
            7'b0010111: begin w_oh[1] = 1'b1; w_imm_fmt = w_imm_u; w_writes = 1'b1; end
            7'b1101111: begin w_oh[2] = 1'b1; w_imm_fmt = w_imm_j; w_writes = 1'b1; end
            7'b1100111: begin
                w_oh[3]   = (w_f3 == 3'b000);
                w_imm_fmt = w_imm_i;
                w_writes  = 1'b1;
            end
            7'b1100011: begin
                w_imm_fmt = w_imm_b;
                case (w_f3)
                    3'b000: w_oh[4] = 1'b1;
                    3'b001: w_oh[5] = 1'b1;
                    3'b100: w_oh[6] = 1'b1;
                    3'b101: w_oh[7] = 1'b1;
                    3'b110: w_oh[8] = 1'b1;
                    3'b111: w_oh[9] = 1'b1;
                    default: ;
                endcase
            end
            7'b0000011: begin
                w_imm_fmt = w_imm_i;
                w_writes  = 1'b1;
                case (w_f3)
                    3'b000: w_oh[10] = 1'b1;
                    3'b001: w_oh[11] = 1'b1;
                    3'b010: w_oh[12] = 1'b1;
                    3'b100: w_oh[13] = 1'b1;
                    3'b101: w_oh[14] = 1'b1;
                    default: ;
                endcase
            end
            7'b0100011: begin
                w_imm_fmt = w_imm_s;
                case (w_f3)
                    3'b000: w_oh[15] = 1'b1;
                    3'b001: w_oh[16] = 1'b1;
                    3'b010: w_oh[17] = 1'b1;
                    default: ;
                endcase
            end
            7'b0010011: begin
                w_imm_fmt = w_imm_i;
                w_writes  = 1'b1;
                // shift-immediates reuse imm[11:5] as funct7, so it must be checked
                case (w_f3)
                    3'b000: w_oh[18] = 1'b1;
                    3'b010: w_oh[19] = 1'b1;
                    3'b011: w_oh[20] = 1'b1;
                    3'b100: w_oh[21] = 1'b1;
                    3'b110: w_oh[22] = 1'b1;
                    3'b111: w_oh[23] = 1'b1;
                    3'b001: w_oh[24] = (w_f7 == 7'b0000000);
                    3'b101: begin
                        w_oh[25] = (w_f7 == 7'b0000000);
                        w_oh[26] = (w_f7 == 7'b0100000);
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                w_writes = 1'b1;
                case (w_f7)
                    7'b0000000: begin
                        case (w_f3)
                            3'b000: w_oh[27] = 1'b1;
                            3'b001: w_oh[29] = 1'b1;
                            3'b010: w_oh[30] = 1'b1;
                            3'b011: w_oh[31] = 1'b1;
                            3'b100: w_oh[32] = 1'b1;
                            3'b101: w_oh[33] = 1'b1;
                            3'b110: w_oh[35] = 1'b1;
                            default: w_oh[36] = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        w_oh[28] = (w_f3 == 3'b000);
                        w_oh[34] = (w_f3 == 3'b101);
                    end
`ifdef RV32_DECODE_M_EXT_EN
                    7'b0000001: w_oh[47:40] = 8'b1 << w_f3;
`else
                    7'b0000001: w_oh[47:40] = 8'b0;
`endif
                    default: ;
                endcase
            end
            7'b0001111: begin w_oh[37] = (w_f3 == 3'b000); w_imm_fmt = w_imm_i; end
            7'b1110011: begin
                w_oh[38] = (in_instr[31:7] == 25'h0000000);
                w_oh[39] = (in_instr[31:7] == 25'h0002000);
            end
            default: ;
        endcase
    end

    // illegal words still travel downstream, but with no immediate and no write
    assign w_illegal = ~|w_oh;
    assign w_accept  = in_valid & r_in_ready;

    always_comb begin
        w_new     = '0;
        w_new.oh  = w_oh;
        w_new.rs1 = in_instr[19:15];
        w_new.rs2 = in_instr[24:20];
        w_new.rd  = in_instr[11:7];
        w_new.we  = w_writes & ~w_illegal & (|in_instr[11:7]);
        w_new.imm = w_illegal ? 32'h0 : w_imm_fmt;
        w_new.pc  = in_pc;
        w_new.ill = w_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid || out_ready) begin
            // skid full implies in_ready was low, so no new word competes with it
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) r_out <= w_new;
            end
            r_in_ready <= 1'b1;
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign instructions = r_out.oh;
    assign rs1_addr     = r_out.rs1;
    assign rs2_addr     = r_out.rs2;
    assign rd_addr      = r_out.rd;
    assign rd_we        = r_out.we;
    assign imm          = r_out.imm;
    assign out_pc       = r_out.pc;
    assign illegal      = r_out.ill;

endmodule

// File: tb/tb_rv32_instr_decoder.sv
// Bench for rv32_instr_decoder: mask/match opcode table model plus an in-order
// scoreboard checked every negedge, directed literal checks, then randomized traffic.
module tb_rv32_instr_decoder;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [47:0] instructions;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rv32_instr_decoder #(.ONEHOT_W(48), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .instructions(instructions),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_we(rd_we),
        .imm(imm), .out_pc(out_pc), .illegal(illegal)
    );

`ifdef RV32_DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    // {mask, match} per one-hot bit, as in the ISA opcode listings
    localparam logic [63:0] TBL [48] = '{
        64'h0000007F_00000037, 64'h0000007F_00000017, 64'h0000007F_0000006F, 64'h0000707F_00000067,
        64'h0000707F_00000063, 64'h0000707F_00001063, 64'h0000707F_00004063, 64'h0000707F_00005063,
        64'h0000707F_00006063, 64'h0000707F_00007063, 64'h0000707F_00000003, 64'h0000707F_00001003,
        64'h0000707F_00002003, 64'h0000707F_00004003, 64'h0000707F_00005003, 64'h0000707F_00000023,
        64'h0000707F_00001023, 64'h0000707F_00002023, 64'h0000707F_00000013, 64'h0000707F_00002013,
        64'h0000707F_00003013, 64'h0000707F_00004013, 64'h0000707F_00006013, 64'h0000707F_00007013,
        64'hFE00707F_00001013, 64'hFE00707F_00005013, 64'hFE00707F_40005013, 64'hFE00707F_00000033,
        64'hFE00707F_40000033, 64'hFE00707F_00001033, 64'hFE00707F_00002033, 64'hFE00707F_00003033,
        64'hFE00707F_00004033, 64'hFE00707F_00005033, 64'hFE00707F_40005033, 64'hFE00707F_00006033,
        64'hFE00707F_00007033, 64'h0000707F_0000000F, 64'hFFFFFFFF_00000073, 64'hFFFFFFFF_00100073,
        64'hFE00707F_02000033, 64'hFE00707F_02001033, 64'hFE00707F_02002033, 64'hFE00707F_02003033,
        64'hFE00707F_02004033, 64'hFE00707F_02005033, 64'hFE00707F_02006033, 64'hFE00707F_02007033
    };

    typedef struct packed {
        logic [47:0] oh;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    function automatic dec_t model(input logic [31:0] w);
        dec_t d;
        int   hit;
        hit = -1;
        for (int k = 0; k < 48; k++)
            if ((k < 40 || M_EN) && ((w & TBL[k][63:32]) == TBL[k][31:0])) hit = k;
        d     = '0;
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.rd  = w[11:7];
        if (hit < 0) begin
            d.ill = 1'b1;
        end else begin
            d.oh[hit] = 1'b1;
            if (hit <= 1)
                d.imm = w & 32'hFFFFF000;
            else if (hit == 2)
                d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            else if (hit == 3 || (hit >= 10 && hit <= 14) || (hit >= 18 && hit <= 26) || hit == 37)
                d.imm = {{20{w[31]}}, w[31:20]};
            else if (hit <= 9)
                d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            else if (hit <= 17)
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            d.we = (d.rd != 5'd0) &&
                   (hit <= 3 || (hit >= 10 && hit <= 14) || (hit >= 18 && hit <= 36) || hit >= 40);
        end
        return d;
    endfunction

    function automatic logic [31:0] gen();
        int          k;
        logic [31:0] w, msk;
        k   = int'($urandom_range(47, 0));
        msk = TBL[k][63:32];
        w   = TBL[k][31:0] | ($urandom & ~msk);
        case ($urandom_range(7, 0))
            0: w = $urandom;
            1: w = w ^ (32'h1 << $urandom_range(31, 0));
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // scoreboard: entries accepted but not yet consumed, {instr, pc}
    logic [63:0] q[$];
    bit          m_started = 1'b0;
    bit          m_rst_prev = 1'b1;
    dec_t        mon_e;

    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", 160'(out_valid), 160'(!m_rst_prev && q.size() > 0));
            chk("in_ready", 160'(in_ready), 160'(!m_rst_prev && q.size() < 2));
            if (m_rst_prev)
                chk("rst_data_zero", 160'({instructions, rs1_addr, rs2_addr, rd_addr, rd_we, imm, out_pc, illegal}), 160'(0));
            else if (out_valid && q.size() > 0) begin
                mon_e = model(q[0][63:32]);
                chk("entry", 160'({instructions, rs1_addr, rs2_addr, rd_addr, rd_we, imm, out_pc, illegal}),
                    160'({mon_e.oh, mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.we, mon_e.imm, q[0][31:0], mon_e.ill}));
            end
        end
        m_started = 1'b1;
        if (rst || flush) q.delete();
        else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back({in_instr, in_pc});
        end
        m_rst_prev = rst;
    end

    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("push_accepted", 160'(done), 160'(1));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t d;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (3) step();
        chk("reset_outputs", 160'({out_valid, in_ready, instructions, imm, rd_we, illegal}), 160'(0));
        rst = 1'b0;
        step();
        chk("ready_after_reset", 160'(in_ready), 160'(1));

        d = model(32'h00500093);
        chk("model_addi", 160'({d.oh, d.imm}), 160'({48'h1 << 18, 32'h5}));
        d = model(32'hFE000EE3);
        chk("model_beq", 160'({d.oh, d.imm, d.we}), 160'({48'h1 << 4, 32'hFFFFFFFC, 1'b0}));
        d = model(32'h0080006F);
        chk("model_jal", 160'({d.oh, d.imm}), 160'({48'h1 << 2, 32'h8}));
        d = model(32'h40005013);
        chk("model_srai", 160'(d.oh), 160'(48'h1 << 26));

        out_ready = 1'b1;
        push(32'h00500093, 32'h0);
        chk("addi", 160'({out_valid, instructions, rs1_addr, rd_addr, rd_we, imm, illegal}),
            160'({1'b1, 48'h1 << 18, 5'd0, 5'd1, 1'b1, 32'h5, 1'b0}));
        push(32'h402081B3, 32'h4);
        chk("sub", 160'({instructions, rs1_addr, rs2_addr, rd_addr, imm}),
            160'({48'h1 << 28, 5'd1, 5'd2, 5'd3, 32'h0}));
        push(32'hFE000EE3, 32'h8);
        chk("beq", 160'({instructions, imm, rd_we}), 160'({48'h1 << 4, 32'hFFFFFFFC, 1'b0}));
        push(32'h027302B3, 32'hC);
`ifdef RV32_DECODE_M_EXT_EN
        chk("mul", 160'({instructions, illegal}), 160'({48'h1 << 40, 1'b0}));
`else
        chk("mul", 160'({instructions, illegal}), 160'({48'h0, 1'b1}));
`endif
        push(32'h00000000, 32'h10);
        chk("zero_word", 160'({out_valid, instructions, illegal}), 160'({1'b1, 48'h0, 1'b1}));
        push(32'h0000707F, 32'h14);
        chk("all_ones_low", 160'({out_valid, instructions, illegal}), 160'({1'b1, 48'h0, 1'b1}));

        // backpressure: A, B accepted, C held until the output drains
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        step(); in_instr = 32'h402081B3; in_pc = 32'h104;
        step();
        chk("bp_ready_low", 160'({in_ready, out_pc}), 160'({1'b0, 32'h100}));
        in_instr = 32'hFE000EE3; in_pc = 32'h108;
        step();
        chk("bp_hold", 160'({in_ready, out_valid, out_pc}), 160'({1'b0, 1'b1, 32'h100}));
        out_ready = 1'b1;
        step();
        chk("bp_second", 160'({out_valid, out_pc}), 160'({1'b1, 32'h104}));
        step();
        chk("bp_third", 160'({out_valid, out_pc}), 160'({1'b1, 32'h108}));
        in_valid = 1'b0;
        step();

        // flush with output and skid both full
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h200;
        step(); in_pc = 32'h204;
        step();
        chk("fl_full", 160'({in_ready, out_valid}), 160'({1'b0, 1'b1}));
        flush = 1'b1; in_pc = 32'h300;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_empty", 160'({out_valid, in_ready}), 160'({1'b0, 1'b1}));
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h400;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_same_cycle", 160'(out_valid), 160'(0));
        step();
        chk("fl_drop_stays", 160'(out_valid), 160'(0));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(63, 0) == 0);
            rst       = ($urandom_range(399, 0) == 0);
            in_instr  = gen();
            in_pc     = $urandom;
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // reset in the middle of a backed-up stream
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h500;
        step(); in_pc = 32'h504;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_zero", 160'({out_valid, in_ready, instructions, rs1_addr, rs2_addr, rd_addr, rd_we, imm, out_pc, illegal}), 160'(0));
        step();
        chk("mid_rst_ready", 160'({in_ready, out_valid}), 160'({1'b1, 1'b0}));
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
